// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
//   Bundles the three writeback sources and the register-file write port
//   shared by rf_wb_arbiter.
//   Sources:   mem_* (load return), lnk_* (jal/jalr link), alu_* (ALU result),
//              each with valid/rd/payload in and ready out.
//   Write port: RFWr, A3, WD, WDSel (00 ALU, 01 MEM, 10 PC).
//   Debug:     lnk_starve_cnt, alu_starve_cnt.
//   slave  : the arbiter side.  master : the requester / register-file side.
interface rf_wb_arbiter_if #(
   parameter int DW = 32,
   parameter int CW = 3
);
   logic          mem_valid;
   logic [4:0]    mem_rd;
   logic [DW-1:0] mem_data;
   logic          mem_ready;

   logic          lnk_valid;
   logic [4:0]    lnk_rd;
   logic [DW-1:0] lnk_pc;
   logic          lnk_ready;

   logic          alu_valid;
   logic [4:0]    alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;

   logic          RFWr;
   logic [4:0]    A3;
   logic [DW-1:0] WD;
   logic [1:0]    WDSel;

   logic [CW-1:0] lnk_starve_cnt;
   logic [CW-1:0] alu_starve_cnt;

   modport slave (
      input  mem_valid, mem_rd, mem_data,
      input  lnk_valid, lnk_rd, lnk_pc,
      input  alu_valid, alu_rd, alu_data,
      output mem_ready, lnk_ready, alu_ready,
      output RFWr, A3, WD, WDSel,
      output lnk_starve_cnt, alu_starve_cnt
   );

   modport master (
      output mem_valid, mem_rd, mem_data,
      output lnk_valid, lnk_rd, lnk_pc,
      output alu_valid, alu_rd, alu_data,
      input  mem_ready, lnk_ready, alu_ready,
      input  RFWr, A3, WD, WDSel,
      input  lnk_starve_cnt, alu_starve_cnt
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates the single register-file write port between load return,
//   link (pc+4) and ALU writeback. One grant per cycle; the granted write is
//   registered and presented on RFWr/A3/WD/WDSel one cycle later.
//   Ports:
//     clk   : rising-edge clock
//     rstn  : asynchronous active-low reset
//     bus   : rf_wb_arbiter_if.slave (source handshakes, write port, debug)
//   Parameters: DW data width (must match bus), STARVE_MAX boost threshold
//   (0 disables boosting), CW starvation counter width (must match bus).
module rf_wb_arbiter #(
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int CW         = 3
) (
   input  logic           clk,
   input  logic           rstn,
   rf_wb_arbiter_if.slave bus
);
   localparam logic [CW-1:0] SMAX     = CW'(STARVE_MAX);
   localparam logic [1:0]    SEL_ALU  = 2'b00;
   localparam logic [1:0]    SEL_MEM  = 2'b01;
   localparam logic [1:0]    SEL_PC   = 2'b10;

   logic [CW-1:0] lnk_cnt, alu_cnt;
   logic          boost_lnk, boost_alu;
   logic          g_mem, g_lnk, g_alu;

   logic          rf_wr_q;
   logic [4:0]    a3_q;
   logic [DW-1:0] wd_q;
   logic [1:0]    wdsel_q;

   assign boost_lnk = (STARVE_MAX != 0) && (lnk_cnt >= SMAX);
   assign boost_alu = (STARVE_MAX != 0) && (alu_cnt >= SMAX);

   // Grant depends only on valids and internal state, never on payloads.
   // Gated by rstn so no source sees ready while reset is held.
   always_comb begin
      g_mem = 1'b0;
      g_lnk = 1'b0;
      g_alu = 1'b0;
      if (rstn) begin
         if (boost_lnk && bus.lnk_valid)      g_lnk = 1'b1;
         else if (boost_alu && bus.alu_valid) g_alu = 1'b1;
         else if (bus.mem_valid)              g_mem = 1'b1;
         else if (bus.lnk_valid)              g_lnk = 1'b1;
         else if (bus.alu_valid)              g_alu = 1'b1;
      end
   end

   assign bus.mem_ready = g_mem;
   assign bus.lnk_ready = g_lnk;
   assign bus.alu_ready = g_alu;

   // Registered write port. Address/data/select hold when idle; only the
   // enable drops. A write to x0 is consumed but never enables the port.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rf_wr_q <= 1'b0;
         a3_q    <= '0;
         wd_q    <= '0;
         wdsel_q <= SEL_ALU;
      end else begin
         rf_wr_q <= 1'b0;
         if (g_mem) begin
            rf_wr_q <= (bus.mem_rd != 5'd0);
            a3_q    <= bus.mem_rd;
            wd_q    <= bus.mem_data;
            wdsel_q <= SEL_MEM;
         end else if (g_lnk) begin
            rf_wr_q <= (bus.lnk_rd != 5'd0);
            a3_q    <= bus.lnk_rd;
            wd_q    <= bus.lnk_pc + DW'(4);   // wraps modulo 2^DW
            wdsel_q <= SEL_PC;
         end else if (g_alu) begin
            rf_wr_q <= (bus.alu_rd != 5'd0);
            a3_q    <= bus.alu_rd;
            wd_q    <= bus.alu_data;
            wdsel_q <= SEL_ALU;
         end
      end
   end

   // Starvation counters: count consecutive denied cycles, saturate at
   // all-ones, clear on grant or when the request goes away.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lnk_cnt <= '0;
         alu_cnt <= '0;
      end else begin
         if (bus.lnk_valid && !g_lnk) begin
            if (lnk_cnt != '1) lnk_cnt <= lnk_cnt + 1'b1;
         end else begin
            lnk_cnt <= '0;
         end
         if (bus.alu_valid && !g_alu) begin
            if (alu_cnt != '1) alu_cnt <= alu_cnt + 1'b1;
         end else begin
            alu_cnt <= '0;
         end
      end
   end

   assign bus.RFWr           = rf_wr_q;
   assign bus.A3             = a3_q;
   assign bus.WD             = wd_q;
   assign bus.WDSel          = wdsel_q;
   assign bus.lnk_starve_cnt = lnk_cnt;
   assign bus.alu_starve_cnt = alu_cnt;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
   logic clk;
   logic rstn;
   int   n_tests = 0;
   int   n_fail  = 0;

   rf_wb_arbiter_if #(.DW(32), .CW(3)) bus ();

   rf_wb_arbiter #(.DW(32), .STARVE_MAX(4), .CW(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then changed
   // and combinational readies checked a further #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [1:0] sel);
      chk({tag, ".RFWr"},  32'(bus.RFWr),  32'(we));
      chk({tag, ".A3"},    32'(bus.A3),    32'(a3));
      chk({tag, ".WD"},    bus.WD,         wd);
      chk({tag, ".WDSel"}, 32'(bus.WDSel), 32'(sel));
   endtask

   initial begin
      // Reset with every source requesting
      rstn = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h0000_AAAA;
      bus.lnk_valid = 1'b1; bus.lnk_rd = 5'd8; bus.lnk_pc   = 32'h0000_0800;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0900;
      #2;
      tick(); tick();
      #1;
      chk("rst.mem_ready", 32'(bus.mem_ready), 32'd0);
      chk("rst.lnk_ready", 32'(bus.lnk_ready), 32'd0);
      chk("rst.alu_ready", 32'(bus.alu_ready), 32'd0);
      chk_wr("rst", 1'b0, 5'd0, 32'd0, 2'b00);
      chk("rst.lnk_cnt", 32'(bus.lnk_starve_cnt), 32'd0);
      chk("rst.alu_cnt", 32'(bus.alu_starve_cnt), 32'd0);

      // Release: MEM wins the first cycle
      rstn = 1'b1;
      #1;
      chk("rel.mem_ready", 32'(bus.mem_ready), 32'd1);
      chk("rel.lnk_ready", 32'(bus.lnk_ready), 32'd0);
      tick();
      bus.mem_valid = 1'b0; bus.lnk_valid = 1'b0; bus.alu_valid = 1'b0;
      #1;
      chk_wr("rel.wr", 1'b1, 5'd7, 32'h0000_AAAA, 2'b01);
      chk("rel.lnk_cnt", 32'(bus.lnk_starve_cnt), 32'd1);
      chk("rel.alu_cnt", 32'(bus.alu_starve_cnt), 32'd1);
      tick();
      chk("idle.alu_cnt", 32'(bus.alu_starve_cnt), 32'd0);
      chk("idle.RFWr", 32'(bus.RFWr), 32'd0);

      // Single ALU write
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_1234;
      #1;
      chk("alu.ready", 32'(bus.alu_ready), 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk_wr("alu.wr", 1'b1, 5'd5, 32'h0000_1234, 2'b00);
      tick();
      chk_wr("alu.hold", 1'b0, 5'd5, 32'h0000_1234, 2'b00);

      // Link write: pc+4
      bus.lnk_valid = 1'b1; bus.lnk_rd = 5'd1; bus.lnk_pc = 32'h0000_0100;
      #1;
      chk("lnk.ready", 32'(bus.lnk_ready), 32'd1);
      tick();
      bus.lnk_rd = 5'd2; bus.lnk_pc = 32'hFFFF_FFFC;
      #1;
      chk_wr("lnk.wr", 1'b1, 5'd1, 32'h0000_0104, 2'b10);
      tick();
      bus.lnk_valid = 1'b0;
      #1;
      chk_wr("lnk.wrap", 1'b1, 5'd2, 32'h0000_0000, 2'b10);

      // ALU write to x0: accepted, no enable
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_0055;
      #1;
      chk("x0.ready", 32'(bus.alu_ready), 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk_wr("x0.wr", 1'b0, 5'd0, 32'h0000_0055, 2'b00);

      // Simultaneous: MEM, then lnk, then alu
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h0000_0300;
      bus.lnk_valid = 1'b1; bus.lnk_rd = 5'd4; bus.lnk_pc   = 32'h0000_0400;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h0000_0600;
      #1;
      chk("sim0.mem_ready", 32'(bus.mem_ready), 32'd1);
      tick();
      bus.mem_valid = 1'b0;
      #1;
      chk_wr("sim1.wr", 1'b1, 5'd3, 32'h0000_0300, 2'b01);
      chk("sim1.lnk_ready", 32'(bus.lnk_ready), 32'd1);
      tick();
      bus.lnk_valid = 1'b0;
      #1;
      chk_wr("sim2.wr", 1'b1, 5'd4, 32'h0000_0404, 2'b10);
      chk("sim2.alu_ready", 32'(bus.alu_ready), 32'd1);
      chk("sim2.alu_cnt", 32'(bus.alu_starve_cnt), 32'd2);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk_wr("sim3.wr", 1'b1, 5'd6, 32'h0000_0600, 2'b00);
      chk("sim3.alu_cnt", 32'(bus.alu_starve_cnt), 32'd0);
      tick();
      chk("sim4.RFWr", 32'(bus.RFWr), 32'd0);

      // Starvation: MEM and ALU held, ALU boosted after 4 denials
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd9;  bus.mem_data = 32'h0000_0900;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h0000_0A00;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stv%0d.alu_cnt", i), 32'(bus.alu_starve_cnt), 32'(i));
         chk($sformatf("stv%0d.mem_ready", i), 32'(bus.mem_ready), 32'd1);
         chk($sformatf("stv%0d.alu_ready", i), 32'(bus.alu_ready), 32'd0);
         tick();
         #1;
      end
      chk("stv4.alu_cnt", 32'(bus.alu_starve_cnt), 32'd4);
      chk("stv4.alu_ready", 32'(bus.alu_ready), 32'd1);
      chk("stv4.mem_ready", 32'(bus.mem_ready), 32'd0);
      tick();
      bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
      #1;
      chk_wr("stv5.wr", 1'b1, 5'd10, 32'h0000_0A00, 2'b00);
      chk("stv5.alu_cnt", 32'(bus.alu_starve_cnt), 32'd0);
      tick();

      // Reset mid-stream drops the registered write at once
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h0000_0BBB;
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("mid.RFWr_pre", 32'(bus.RFWr), 32'd1);
      rstn = 1'b0;
      #1;
      chk_wr("mid.rst", 1'b0, 5'd0, 32'd0, 2'b00);
      tick();
      rstn = 1'b1;
      tick();
      chk_wr("mid.after", 1'b0, 5'd0, 32'd0, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port between three writeback requesters: load data from memory, the jal/jalr link value, and the ALU result. Arbitrates with a valid/ready handshake per source and registers the winning write one cycle later. Also emits the existing WDSel encoding so datapath debug and trace logic keep working. Sits between execute/memory-return logic and the register file write port (RFWr, A3, WD), replacing direct mux-driven writeback once loads become multi-cycle.

Parameters:
DW, 32, data width of WD and all source payloads
STARVE_MAX, 4, consecutive denied cycles before a link or ALU request is boosted above MEM; 0 disables boosting
CW, 3, starvation counter width; must hold STARVE_MAX

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous assert, active-low
mem_valid  in  1  load data available
mem_rd  in  5  load destination register
mem_data  in  DW  load data
mem_ready  out  1  load data accepted this cycle
lnk_valid  in  1  link write request (jal/jalr)
lnk_rd  in  5  link destination register
lnk_pc  in  DW  PC of the jump; the block writes lnk_pc+4
lnk_ready  out  1  link request accepted
alu_valid  in  1  ALU write request
alu_rd  in  5  ALU destination register
alu_data  in  DW  ALU result
alu_ready  out  1  ALU request accepted
RFWr  out  1  register-file write enable
A3  out  5  write address
WD  out  DW  write data
WDSel  out  2  source of the current write: 00 ALU, 01 MEM, 10 PC
lnk_starve_cnt  out  CW  debug: link starvation count
alu_starve_cnt  out  CW  debug: ALU starvation count

Behaviour:
- Reset: rstn low asynchronously clears RFWr, A3, WD, WDSel, and both starvation counters to 0. Readies are 0 while rstn is low. A request in flight at reset is dropped; no write occurs after reset deasserts unless it is re-requested.
- Grant, combinational, at most one per cycle:
  - boost_x = (STARVE_MAX != 0) && (x_cnt >= STARVE_MAX), for x in {lnk, alu}.
  - Priority order: boosted lnk > boosted alu > mem > lnk > alu. Only a source with valid=1 can be granted.
  - x_ready = grant_x. ready depends only on the valid inputs and internal state, never on payloads.
- Transfer occurs when valid && ready. Sources hold valid and payload stable until ready is seen.
- Write path, registered, latency 1 cycle:
  - On a grant at edge N, at edge N+1: RFWr = (rd != 0), A3 = rd, WD = payload, WDSel = code.
  - Link payload = lnk_pc + 4, computed modulo 2^DW (0xFFFFFFFC wraps to 0).
  - A granted write to x0 is accepted (ready=1) but produces RFWr=0. A3, WD and WDSel still update.
  - With no grant, RFWr=0 and A3/WD/WDSel hold their previous values.
- Starvation counters, per lnk and alu:
  - valid && !grant: increment, saturating at 2^CW-1.
  - grant, or valid=0: clear to 0.
- The MEM source has no counter. Under continuous boosted traffic it can be delayed; the memory side buffers or holds mem_valid.
- The block performs no back-to-back hazard checks. Forwarding is outside this block.

Test Plan:
- Reset: drive all valids high with rstn=0 -> all readies 0, RFWr=0, A3=0, WD=0, WDSel=00, counters 0. Release rstn -> MEM is granted in the first cycle.
- Single ALU write: alu_valid=1, rd=5, data=0x1234 for one cycle -> alu_ready=1 that cycle; next cycle RFWr=1, A3=5, WD=0x1234, WDSel=00; the following cycle RFWr=0.
- Link and x0: lnk rd=1, pc=0x100 -> WD=0x104, WDSel=10. lnk pc=0xFFFFFFFC -> WD=0. alu rd=0 -> alu_ready=1, RFWr stays 0.
- Simultaneous requests: all three valid and held -> grants MEM, then lnk, then alu on consecutive cycles; writes appear in that order one cycle later.
- Starvation (STARVE_MAX=4): mem_valid and alu_valid held high -> alu_starve_cnt goes 0,1,2,3,4; alu is granted on the 5th cycle; mem_ready=0 that cycle; the counter returns to 0.
- Reset mid-stream: assert rstn low in the cycle after a grant -> RFWr drops immediately (asynchronously) and the pending write never appears.
